// File: rtl/register_file_mp_pkg.sv
// Shared sizing constants for the multi-port register file and its scoreboard.
package register_file_mp_pkg;

  localparam int REGISTER_ADDRESS_BITS = 3;
  localparam int REGISTER_DATA_BITS    = 8;
  localparam int REGISTER_COUNT        = 2 ** REGISTER_ADDRESS_BITS;
  localparam int REGISTER_READ_PORTS   = 2;

endpackage

// File: rtl/register_file_mp_if.sv
// Read / writeback / issue-claim bundle between the CPU pipeline (master)
// and the register file (slave).
interface register_file_mp_if
  import register_file_mp_pkg::*;
#(
  parameter int ADDR_BITS    = REGISTER_ADDRESS_BITS,
  parameter int DATA_BITS    = REGISTER_DATA_BITS,
  parameter int NUM_RD_PORTS = REGISTER_READ_PORTS
);

  logic [NUM_RD_PORTS*ADDR_BITS-1:0] rd_addr;
  logic [NUM_RD_PORTS-1:0]           rd_enable;
  logic [NUM_RD_PORTS*DATA_BITS-1:0] rd_data;
  logic [NUM_RD_PORTS-1:0]           rd_busy;
  logic [ADDR_BITS-1:0]              wr_addr;
  logic                              wr_enable;
  logic [DATA_BITS-1:0]              wr_data;
  logic [ADDR_BITS-1:0]              claim_addr;
  logic                              claim_enable;
  logic                              claim_accept;
  logic [ADDR_BITS:0]                busy_count;

  modport master (
    output rd_addr, rd_enable, wr_addr, wr_enable, wr_data, claim_addr, claim_enable,
    input  rd_data, rd_busy, claim_accept, busy_count
  );

  modport slave (
    input  rd_addr, rd_enable, wr_addr, wr_enable, wr_data, claim_addr, claim_enable,
    output rd_data, rd_busy, claim_accept, busy_count
  );

endinterface

// File: rtl/register_file_mp_reg_scoreboard.sv
// Per-register busy tracking for out-of-order writeback: claim sets, write clears,
// with a running count of outstanding producers.
module reg_scoreboard
  import register_file_mp_pkg::*;
#(
  parameter int DEPTH        = REGISTER_COUNT,
  parameter int ADDR_BITS    = REGISTER_ADDRESS_BITS,
  parameter int NUM_RD_PORTS = REGISTER_READ_PORTS,
  parameter int ZERO_REG     = 0,
  parameter int BYPASS       = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              wr_enable,
  input  logic [ADDR_BITS-1:0]              wr_addr,
  input  logic                              claim_enable,
  input  logic [ADDR_BITS-1:0]              claim_addr,
  input  logic [NUM_RD_PORTS*ADDR_BITS-1:0] rd_addr,
  output logic                              claim_accept,
  output logic [NUM_RD_PORTS-1:0]           rd_busy,
  output logic [ADDR_BITS:0]                busy_count
);

  logic [DEPTH-1:0]   busy_q, busy_d;
  logic [ADDR_BITS:0] busy_count_q, busy_count_d;
  logic               wr_hit_claim, claim_zero, accept_c, inc, dec;

  always_comb begin
    wr_hit_claim = wr_enable && (wr_addr == claim_addr);
    claim_zero   = (ZERO_REG != 0) && (claim_addr == '0);
    // A busy register may be re-claimed only when its producer retires this same cycle.
    accept_c     = claim_enable && !claim_zero && (!busy_q[claim_addr] || wr_hit_claim);
    busy_d       = busy_q;
    inc          = 1'b0;
    dec          = 1'b0;
    if (wr_enable && !(accept_c && wr_hit_claim)) begin
      dec             = busy_q[wr_addr];
      busy_d[wr_addr] = 1'b0;
    end
    if (accept_c) begin
      inc                = !busy_q[claim_addr];
      busy_d[claim_addr] = 1'b1;
    end
    busy_count_d = busy_count_q + {{ADDR_BITS{1'b0}}, inc} - {{ADDR_BITS{1'b0}}, dec};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd_busy
      logic [ADDR_BITS-1:0] addr;
      logic                 retiring, zero_hit;
      assign addr     = rd_addr[gi*ADDR_BITS +: ADDR_BITS];
      assign retiring = (BYPASS != 0) && wr_enable && (wr_addr == addr);
      assign zero_hit = (ZERO_REG != 0) && (addr == '0);
      assign rd_busy[gi] = busy_q[addr] && !retiring && !zero_hit;
    end
  endgenerate

  assign claim_accept = accept_c;
  assign busy_count   = busy_count_q;

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-read-port register file with registered reads,
// optional write-to-read bypass, optional hardwired-zero r0 and a busy scoreboard.
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int ADDR_BITS    = REGISTER_ADDRESS_BITS,
  parameter int DATA_BITS    = REGISTER_DATA_BITS,
  parameter int NUM_RD_PORTS = REGISTER_READ_PORTS,
  parameter int ZERO_REG     = 0,
  parameter int BYPASS       = 1
) (
  input  logic               clk,
  input  logic               reset,
  register_file_mp_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [DATA_BITS-1:0] mem_d [DEPTH];
  logic                 wr_drop;

  always_comb begin
    wr_drop = (ZERO_REG != 0) && (bus.wr_addr == '0);
    mem_d   = mem_q;
    if (bus.wr_enable && !wr_drop) begin
      mem_d[bus.wr_addr] = bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd
      logic [ADDR_BITS-1:0] addr;
      logic                 zero_hit, fwd_hit;
      logic [DATA_BITS-1:0] rd_data_q, rd_data_d;

      assign addr = bus.rd_addr[gi*ADDR_BITS +: ADDR_BITS];

      always_comb begin
        zero_hit  = (ZERO_REG != 0) && (addr == '0);
        fwd_hit   = (BYPASS != 0) && bus.wr_enable && (bus.wr_addr == addr);
        rd_data_d = rd_data_q;
        if (bus.rd_enable[gi]) begin
          if (zero_hit)     rd_data_d = '0;
          else if (fwd_hit) rd_data_d = bus.wr_data;
          else              rd_data_d = mem_q[addr];
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_data_q <= '0;
        else        rd_data_q <= rd_data_d;
      end

      assign bus.rd_data[gi*DATA_BITS +: DATA_BITS] = rd_data_q;
    end
  endgenerate

  reg_scoreboard #(
    .DEPTH        (DEPTH),
    .ADDR_BITS    (ADDR_BITS),
    .NUM_RD_PORTS (NUM_RD_PORTS),
    .ZERO_REG     (ZERO_REG),
    .BYPASS       (BYPASS)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .wr_enable    (bus.wr_enable),
    .wr_addr      (bus.wr_addr),
    .claim_enable (bus.claim_enable),
    .claim_addr   (bus.claim_addr),
    .rd_addr      (bus.rd_addr),
    .claim_accept (bus.claim_accept),
    .rd_busy      (bus.rd_busy),
    .busy_count   (bus.busy_count)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// Drives two configurations (4 ports/zero-r0/bypass and 2 ports/plain/no-bypass)
// with identical stimulus and compares both against an array-based reference model.
module tb_register_file_mp;

  localparam int AB = 3;
  localparam int DB = 8;
  localparam int PA = 4;
  localparam int PB = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  register_file_mp_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_RD_PORTS(PA)) bus_a();
  register_file_mp_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_RD_PORTS(PB)) bus_b();

  register_file_mp #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_RD_PORTS(PA),
                     .ZERO_REG(1), .BYPASS(1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  register_file_mp #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_RD_PORTS(PB),
                     .ZERO_REG(0), .BYPASS(0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // stimulus shared by both instances
  logic [2:0] s_rd_addr [4];
  logic       s_rd_en   [4];
  logic       s_wr_en, s_claim_en;
  logic [2:0] s_wr_addr, s_claim_addr;
  logic [7:0] s_wr_data;

  assign bus_a.rd_addr      = {s_rd_addr[3], s_rd_addr[2], s_rd_addr[1], s_rd_addr[0]};
  assign bus_a.rd_enable    = {s_rd_en[3], s_rd_en[2], s_rd_en[1], s_rd_en[0]};
  assign bus_a.wr_enable    = s_wr_en;
  assign bus_a.wr_addr      = s_wr_addr;
  assign bus_a.wr_data      = s_wr_data;
  assign bus_a.claim_enable = s_claim_en;
  assign bus_a.claim_addr   = s_claim_addr;
  assign bus_b.rd_addr      = {s_rd_addr[1], s_rd_addr[0]};
  assign bus_b.rd_enable    = {s_rd_en[1], s_rd_en[0]};
  assign bus_b.wr_enable    = s_wr_en;
  assign bus_b.wr_addr      = s_wr_addr;
  assign bus_b.wr_data      = s_wr_data;
  assign bus_b.claim_enable = s_claim_en;
  assign bus_b.claim_addr   = s_claim_addr;

  // reference model, index 0 = instance a, 1 = instance b
  logic [7:0] m_mem  [2][8];
  bit         m_busy [2][8];
  logic [7:0] m_rd   [2][4];
  bit         m_acc  [2];
  int         cfg_zr [2] = '{1, 0};
  int         cfg_by [2] = '{1, 0};
  int         cfg_np [2] = '{PA, PB};

  int n_checks = 0;
  int n_fail   = 0;
  int n_cycle  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dut_rd(int c, int p);
    if (c == 0) return bus_a.rd_data[p*8 +: 8];
    return bus_b.rd_data[p*8 +: 8];
  endfunction

  function automatic logic dut_rbusy(int c, int p);
    if (c == 0) return bus_a.rd_busy[p];
    return bus_b.rd_busy[p];
  endfunction

  function automatic logic dut_acc(int c);
    return (c == 0) ? bus_a.claim_accept : bus_b.claim_accept;
  endfunction

  function automatic logic [3:0] dut_cnt(int c);
    return (c == 0) ? bus_a.busy_count : bus_b.busy_count;
  endfunction

  function automatic int popcount(int c);
    int n = 0;
    for (int r = 0; r < 8; r++) n += m_busy[c][r] ? 1 : 0;
    return n;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 8; r++) begin
        m_mem[c][r]  = 8'h00;
        m_busy[c][r] = 1'b0;
      end
      for (int p = 0; p < 4; p++) m_rd[c][p] = 8'h00;
    end
  endtask

  task automatic idle();
    for (int p = 0; p < 4; p++) begin
      s_rd_addr[p] = 3'd0;
      s_rd_en[p]   = 1'b0;
    end
    s_wr_en = 1'b0; s_wr_addr = 3'd0; s_wr_data = 8'h00;
    s_claim_en = 1'b0; s_claim_addr = 3'd0;
  endtask

  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  task automatic check_all_zero(input string tag);
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < cfg_np[c]; p++)
        chk($sformatf("%s c%0d rd%0d", tag, c, p), {24'h0, dut_rd(c, p)}, 32'h0);
      chk($sformatf("%s c%0d count", tag, c), {28'h0, dut_cnt(c)}, 32'h0);
    end
  endtask

  // one clock: combinational checks before the edge, model update, registered checks after
  task automatic cycle();
    bit exp_rb;
    #1;
    for (int c = 0; c < 2; c++) begin
      m_acc[c] = s_claim_en && !(cfg_zr[c] != 0 && s_claim_addr == 0) &&
                 (!m_busy[c][s_claim_addr] || (s_wr_en && s_wr_addr == s_claim_addr));
      chk($sformatf("c%0d accept", c), {31'h0, dut_acc(c)}, {31'h0, m_acc[c]});
      for (int p = 0; p < cfg_np[c]; p++) begin
        exp_rb = m_busy[c][s_rd_addr[p]] &&
                 !(cfg_by[c] != 0 && s_wr_en && s_wr_addr == s_rd_addr[p]) &&
                 !(cfg_zr[c] != 0 && s_rd_addr[p] == 0);
        chk($sformatf("c%0d rd_busy%0d", c, p), {31'h0, dut_rbusy(c, p)}, {31'h0, exp_rb});
      end
    end
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < cfg_np[c]; p++) begin
        if (s_rd_en[p]) begin
          if (cfg_zr[c] != 0 && s_rd_addr[p] == 0)                        m_rd[c][p] = 8'h00;
          else if (cfg_by[c] != 0 && s_wr_en && s_wr_addr == s_rd_addr[p]) m_rd[c][p] = s_wr_data;
          else                                                             m_rd[c][p] = m_mem[c][s_rd_addr[p]];
        end
      end
      if (s_wr_en && !(m_acc[c] && s_wr_addr == s_claim_addr)) m_busy[c][s_wr_addr] = 1'b0;
      if (m_acc[c]) m_busy[c][s_claim_addr] = 1'b1;
      if (s_wr_en && !(cfg_zr[c] != 0 && s_wr_addr == 0)) m_mem[c][s_wr_addr] = s_wr_data;
    end
    #1;
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < cfg_np[c]; p++)
        chk($sformatf("c%0d rd_data%0d", c, p), {24'h0, dut_rd(c, p)}, {24'h0, m_rd[c][p]});
      chk($sformatf("c%0d busy_count", c), {28'h0, dut_cnt(c)}, popcount(c));
    end
    n_cycle++;
    $display("cyc %0d wr=%0b a%0d d%02h claim=%0b a%0d acc=%0b/%0b cnt=%0d/%0d rd_a=%02h,%02h,%02h,%02h",
             n_cycle, s_wr_en, s_wr_addr, s_wr_data, s_claim_en, s_claim_addr,
             m_acc[0], m_acc[1], dut_cnt(0), dut_cnt(1),
             dut_rd(0, 0), dut_rd(0, 1), dut_rd(0, 2), dut_rd(0, 3));
  endtask

  initial begin
    idle();
    model_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // write r5, read it next cycle on port 1, then same-cycle write+read
    nxt(); s_wr_en = 1; s_wr_addr = 3'd5; s_wr_data = 8'hA7; cycle();
    nxt(); s_rd_en[1] = 1; s_rd_addr[1] = 3'd5; cycle();
    nxt(); s_wr_en = 1; s_wr_addr = 3'd5; s_wr_data = 8'h3C;
           s_rd_en[1] = 1; s_rd_addr[1] = 3'd5; cycle();

    // r0 write and claim
    nxt(); s_wr_en = 1; s_wr_addr = 3'd0; s_wr_data = 8'hFF;
           s_claim_en = 1; s_claim_addr = 3'd0; cycle();
    nxt(); for (int p = 0; p < 4; p++) begin s_rd_en[p] = 1; s_rd_addr[p] = 3'd0; end cycle();

    // claim r2, WAW reject, write+reclaim, read back
    nxt(); s_claim_en = 1; s_claim_addr = 3'd2; cycle();
    nxt(); s_claim_en = 1; s_claim_addr = 3'd2; s_rd_addr[0] = 3'd2; s_rd_addr[1] = 3'd2; cycle();
    nxt(); s_claim_en = 1; s_claim_addr = 3'd2; s_wr_en = 1; s_wr_addr = 3'd2; s_wr_data = 8'h11;
           s_rd_addr[1] = 3'd2; cycle();
    nxt(); s_rd_en[0] = 1; s_rd_addr[0] = 3'd2; s_rd_en[1] = 1; s_rd_addr[1] = 3'd2; cycle();

    // claim everything, then retire everything
    for (int r = 0; r < 8; r++) begin
      nxt(); s_claim_en = 1; s_claim_addr = 3'(r); cycle();
    end
    for (int r = 0; r < 8; r++) begin
      nxt(); s_wr_en = 1; s_wr_addr = 3'(r); s_wr_data = 8'(8'h20 + r); cycle();
    end
    nxt(); s_wr_en = 1; s_wr_addr = 3'd3; s_wr_data = 8'h99; cycle();
    nxt(); s_claim_en = 1; s_claim_addr = 3'd4; cycle();
    nxt(); s_claim_en = 1; s_claim_addr = 3'd1; s_wr_en = 1; s_wr_addr = 3'd4; s_wr_data = 8'h44; cycle();

    // all ports on r6 with port 2 disabled and holding an older value
    nxt(); s_wr_en = 1; s_wr_addr = 3'd6; s_wr_data = 8'h42;
           s_rd_en[2] = 1; s_rd_addr[2] = 3'd4; cycle();
    nxt(); for (int p = 0; p < 4; p++) begin s_rd_en[p] = (p != 2); s_rd_addr[p] = 3'd6; end cycle();

    // asynchronous reset in the middle of a cycle
    nxt(); s_wr_en = 1; s_wr_addr = 3'd3; s_wr_data = 8'h5A; s_claim_en = 1; s_claim_addr = 3'd3; cycle();
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(negedge clk); idle(); reset = 1'b1;
    for (int p = 0; p < 4; p++) begin s_rd_en[p] = 1; s_rd_addr[p] = 3'd3; end
    cycle();

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      nxt();
      for (int p = 0; p < 4; p++) begin
        s_rd_en[p]   = 1'($urandom_range(0, 1));
        s_rd_addr[p] = 3'($urandom_range(0, 7));
      end
      s_wr_en      = ($urandom_range(0, 2) != 0);
      s_wr_addr    = 3'($urandom_range(0, 7));
      s_wr_data    = 8'($urandom);
      s_claim_en   = 1'($urandom_range(0, 1));
      s_claim_addr = ($urandom_range(0, 3) == 0) ? s_wr_addr : 3'($urandom_range(0, 7));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
